// File: rtl/rx_pkg.sv
// rx_pkg: shared state encoding and parameter defaults for the rx_ctrl capture block.
package rx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2} rx_state_e;
  localparam int FIFO_AW_DEF = 4;
  localparam logic [15:0] HDR_MAGIC_DEF = 16'hA5C3;
endpackage

// File: rtl/rx_ctrl_if.sv
// rx_ctrl_if: AXI-stream output bundle; master drives data/valid/last, slave drives ready.
interface rx_ctrl_if;
  logic [31:0] rx_tdata;
  logic rx_tvalid;
  logic rx_tready;
  logic rx_tlast;
  modport master(output rx_tdata, rx_tvalid, rx_tlast, input rx_tready);
  modport slave(input rx_tdata, rx_tvalid, rx_tlast, output rx_tready);
endinterface

// File: rtl/rx_fifo.sv
// rx_fifo: synchronous first-word-fall-through FIFO; a pop frees a slot for a same-edge push.
module rx_fifo #(
  parameter int AW = 4,
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  logic [W-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign rd = pop_i && !empty_o;
  assign wr = push_i && (!full_o || rd);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(wr);
      rd_q <= rd_q + AW'(rd);
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_q] <= wdata_i;
  assign rdata_o = mem_q[rd_q];
  assign full_o = cnt_q == (AW+1)'(2**AW);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/rx_ctrl.sv
// rx_ctrl: triggered ADC capture into a FWFT FIFO drained over AXI-stream.
// Define RX_CTRL_HEADER_EN to prefix each capture with a {HDR_MAGIC, seq} header word.
module rx_ctrl
  import rx_pkg::*;
#(
  parameter int FIFO_AW = FIFO_AW_DEF,
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [15:0] rxsmps,
  input  logic [31:0] adc,
  rx_ctrl_if.master   rx,
  output logic        busy,
  output logic        overflow
);
  rx_state_e state_q;
  logic [15:0] n_q, cnt_q, cnt_d;
  logic overflow_q, accept, cap, pop, push, full, empty, drop;
  logic [31:0] wdata, rdata;
  logic [FIFO_AW:0] count;
  assign accept = state_q == IDLE && trig && rxsmps != '0;
  assign cap = state_q == CAPTURE;
  assign cnt_d = cnt_q + 16'd1;
  assign pop = !empty && rx.rx_tready;
  assign drop = cap && full && !pop;
`ifdef RX_CTRL_HEADER_EN
  logic [15:0] seq_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) seq_q <= '0;
    else if (accept) seq_q <= seq_q + 16'd1;
  assign push = accept || cap;
  assign wdata = cap ? adc : {HDR_MAGIC, seq_q};
`else
  logic unused_hdr;
  assign unused_hdr = ^HDR_MAGIC;
  assign push = cap;
  assign wdata = adc;
`endif
  rx_fifo #(.AW(FIFO_AW), .W(32)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .wdata_i(wdata),
    .pop_i(pop),
    .rdata_o(rdata),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
  assign rx.rx_tvalid = !empty;
  assign rx.rx_tdata = empty ? '0 : rdata;
  assign rx.rx_tlast = state_q == DRAIN && count == (FIFO_AW+1)'(1) && !empty;
  assign busy = state_q != IDLE;
  assign overflow = overflow_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= accept ? 1'b0 : overflow_q | drop;
      case (state_q)
        IDLE: if (accept) begin
          n_q <= rxsmps;
          cnt_q <= '0;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          cnt_q <= cnt_d;
          if (cnt_d == n_q) state_q <= DRAIN;
        end
        DRAIN: if (pop && rx.rx_tlast) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rx_ctrl.sv
// tb_rx_ctrl: directed vector table plus a cycle-level reference queue for multi-cycle captures.
module tb_rx_ctrl;
  import rx_pkg::*;
`ifdef RX_CTRL_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  logic clk = 0, rst = 1, trig = 0, busy, overflow;
  logic [15:0] rxsmps = 0;
  logic [31:0] adc = 0;
  rx_ctrl_if rx();
  rx_ctrl dut (.clk(clk), .rst(rst), .trig(trig), .rxsmps(rxsmps), .adc(adc), .rx(rx), .busy(busy), .overflow(overflow));
  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  logic [31:0] q[$];
  logic ovf_m = 0;
  logic [15:0] seq_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tvalid"}, 32'(rx.rx_tvalid), 0);
    chk({tag, "_tdata"}, rx.rx_tdata, 0);
    chk({tag, "_tlast"}, 32'(rx.rx_tlast), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // mode 0: ready always, 1: ready only after the last sample edge, 2: random 50 %
  task automatic run_capture(input int n, input int base, input int mode, input bit retrig, input int exp_words);
    bit cap_busy = 0, drain = 0, done = 0, pop, rdy, stall = 0;
    int c = 0, words = 0, lasts = 0;
    logic [31:0] pd = 0;
    while (!done && c < n + 200) begin
      @(negedge clk);
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (c > n) : 1'($urandom_range(0, 1));
      trig = (c == 0) || (retrig && c == 2);
      rxsmps = c == 0 ? n[15:0] : 16'd7;
      adc = 32'(base + c);
      rx.rx_tready = rdy;
      #1;
      chk("tvalid", 32'(rx.rx_tvalid), 32'(q.size() != 0));
      chk("tdata", rx.rx_tdata, q.size() != 0 ? q[0] : 32'd0);
      chk("tlast", 32'(rx.rx_tlast), 32'(drain && q.size() == 1));
      chk("busy", 32'(busy), 32'(cap_busy));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      if (stall) chk("stall_hold", rx.rx_tdata, pd);
      stall = q.size() != 0 && !rdy;
      pd = rx.rx_tdata;
      pop = q.size() != 0 && rdy;
      if (pop) begin
        words++;
        if (rx.rx_tlast) lasts++;
        if (drain && q.size() == 1) done = 1;
        void'(q.pop_front());
      end
      if (c == 0) begin
        cap_busy = 1;
        ovf_m = 0;
`ifdef RX_CTRL_HEADER_EN
        q.push_back({HDR_MAGIC_DEF, seq_m});
        seq_m++;
`endif
      end else if (c <= n) begin
        if (q.size() < 16) q.push_back(32'(base + c));
        else ovf_m = 1;
        if (c == n) drain = 1;
      end
      if (done) cap_busy = 0;
      c++;
    end
    trig = 0;
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL capture_timeout: n=%0d no final handshake within %0d cycles", n, n + 200);
    end
    chk("tlast_count", 32'(lasts), 1);
    if (exp_words >= 0) chk("word_count", 32'(words), 32'(exp_words));
    @(negedge clk);
    #1;
    chk_idle("post");
    chk("post_overflow", 32'(overflow), 32'(ovf_m));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk_idle("rst");
    chk("rst_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst = 0;
    q.delete();
    ovf_m = 0;
    seq_m = 0;
  endtask

  typedef struct {
    logic t; logic [15:0] n; logic r;
    logic v; logic [31:0] d; logic l; logic b; logic o;
  } vec_t;
  vec_t tbl[15];

  initial begin
    rx.rx_tready = 0;
    @(negedge clk);
    #1;
    chk_idle("init");
    chk("init_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst = 0;
`ifndef RX_CTRL_HEADER_EN
    tbl[0]  = '{1, 4, 1, 0, 0,   0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0,   0, 1, 0};
    tbl[2]  = '{0, 0, 1, 1, 101, 0, 1, 0};
    tbl[3]  = '{0, 0, 1, 1, 102, 0, 1, 0};
    tbl[4]  = '{0, 0, 1, 1, 103, 0, 1, 0};
    tbl[5]  = '{0, 0, 1, 1, 104, 1, 1, 0};
    tbl[6]  = '{1, 2, 0, 0, 0,   0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0,   0, 1, 0};
    tbl[8]  = '{0, 0, 0, 1, 107, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 1, 107, 0, 1, 0};
    tbl[10] = '{1, 5, 0, 1, 107, 0, 1, 0};
    tbl[11] = '{0, 0, 1, 1, 107, 0, 1, 0};
    tbl[12] = '{1, 3, 1, 1, 108, 1, 1, 0};
    tbl[13] = '{1, 0, 1, 0, 0,   0, 0, 0};
    tbl[14] = '{0, 0, 1, 0, 0,   0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      trig = tbl[i].t;
      rxsmps = tbl[i].n;
      rx.rx_tready = tbl[i].r;
      adc = 32'(100 + i);
      #1;
      chk($sformatf("v%0d_tvalid", i), 32'(rx.rx_tvalid), 32'(tbl[i].v));
      chk($sformatf("v%0d_tdata", i), rx.rx_tdata, tbl[i].d);
      chk($sformatf("v%0d_tlast", i), 32'(rx.rx_tlast), 32'(tbl[i].l));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(tbl[i].o));
    end
    trig = 0;
`endif
    run_capture(4, 100, 0, 0, 4 + HDR);
    run_capture(20, 1000, 1, 0, 16);
    chk("ovf_after_20", 32'(overflow), 1);
    run_capture(100, 2000, 2, 1, -1);
    @(negedge clk);
    trig = 1;
    rxsmps = 50;
    adc = 0;
    rx.rx_tready = 0;
    @(negedge clk);
    trig = 0;
    repeat (20) @(negedge clk);
    #1;
    chk("pre_rst_ovf", 32'(overflow), 1);
    chk("pre_rst_tvalid", 32'(rx.rx_tvalid), 1);
    chk("pre_rst_busy", 32'(busy), 1);
    do_reset();
    run_capture(3, 3000, 0, 0, 3 + HDR);
`ifdef RX_CTRL_HEADER_EN
    do_reset();
    run_capture(2, 4000, 0, 0, 3);
    run_capture(2, 5000, 0, 0, 3);
`endif
    run_capture(65535, 0, 0, 0, 65535 + HDR);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
